x1_uart_reporter: RTL and testbench

- Consumes the processor's debug register output `x1`.
- Whenever `x1` changes, it transmits the new value over a UART TX line as 8 uppercase hex ASCII digits (MSB nibble first), followed by CR and LF.
- Sits between the processor and the board's serial pin, so register activity is visible on a host terminal without LEDs.
- Values that change while a frame is in flight are coalesced into a single pending slot; overwritten values are counted.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_byte.sv | 70 +++++++
 rtl/x1_uart_reporter.sv | 135 +++++++++++++
 tb/tb_x1_uart_reporter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the x1 UART reporter: ASCII constants, frame length,
// FSM state encodings and the nibble-to-hex mapping.
package uart_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Eight hex digits followed by CR and LF.
  localparam int FRAME_CHARS = 10;

  // Reporter (frame-level) states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rep_state_t;

  // Byte transmitter states.
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  // Map a 4-bit value to its uppercase ASCII hex digit.
  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'd0, n};
    else           return ASCII_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A byte is accepted on valid && ready; the start bit is
// driven from the accepting edge. ready is also high in the last cycle of the
// stop bit so that a following byte is chained with no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]       shreg;     // remaining data bits with the stop bit behind them
  logic             bit_end;
  logic             last_cycle;
  logic             accept;

  assign bit_end    = (baud_cnt == CNT_LAST);
  assign last_cycle = (state == TX_BUSY) && bit_end && (bit_idx == 4'd9);
  assign ready      = (state == TX_IDLE) || last_cycle;
  assign accept     = valid && ready;

  // Bit timing and line control: start bit on accept, next bit at each bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
    end else if (accept) begin
      state    <= TX_BUSY;
      tx       <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
    end else if (state == TX_BUSY) begin
      if (last_cycle) begin
        state    <= TX_IDLE;
        tx       <= 1'b1;
        baud_cnt <= '0;
        bit_idx  <= 4'd0;
      end else if (bit_end) begin
        baud_cnt <= '0;
        bit_idx  <= bit_idx + 4'd1;
        tx       <= shreg[0];
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  // Data shift register: loaded on accept, shifted as each bit is put on the line.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= {1'b1, data};
    end else if ((state == TX_BUSY) && bit_end && !last_cycle) begin
      shreg <= {1'b1, shreg[8:1]};
    end
  end

endmodule

// File: rtl/x1_uart_reporter.sv
// Reports every new value of the processor's x1 register over UART as eight
// uppercase hex digits plus CR LF. Values arriving mid-frame are coalesced into
// a single pending slot; overwritten pending values are counted in drop_count.
module x1_uart_reporter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] x1,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam logic [3:0] LAST_CHAR = 4'(FRAME_CHARS - 1);

  rep_state_t  state;
  logic [31:0] cur_val;
  logic [31:0] last_sent;
  logic [31:0] pending_val;
  logic        pending_valid;
  logic [3:0]  char_idx;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        change;
  logic        frame_end;
  logic        start;

  // Character idx of a frame carrying val: hex digits MSB first, then CR, LF.
  function automatic logic [7:0] char_of(input logic [3:0] idx, input logic [31:0] val);
    logic [3:0] nib;
    nib = val[{3'd7 - idx[2:0], 2'b00} +: 4];
    case (idx)
      4'd8:    return ASCII_CR;
      4'd9:    return ASCII_LF;
      default: return nibble_to_hex(nib);
    endcase
  endfunction

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next-byte selection and change detection.
  always_comb begin
    change    = (x1 != last_sent) && !(pending_valid && (x1 == pending_val));
    start     = (state == ST_IDLE) && (x1 != last_sent);
    frame_end = (state == ST_SEND) && tx_ready && (char_idx == LAST_CHAR);
    tx_valid  = 1'b0;
    tx_data   = char_of(4'd0, x1);
    if (state == ST_IDLE) begin
      tx_valid = (x1 != last_sent);
      tx_data  = char_of(4'd0, x1);
    end else if (char_idx == LAST_CHAR) begin
      tx_valid = pending_valid;
      tx_data  = char_of(4'd0, pending_val);
    end else begin
      tx_valid = 1'b1;
      tx_data  = char_of(char_idx + 4'd1, cur_val);
    end
  end

  // Frame FSM: starts frames, advances characters, chains pending values, counts drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      last_sent     <= '0;
      pending_valid <= 1'b0;
      drop_count    <= '0;
      char_idx      <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            last_sent <= x1;
            char_idx  <= 4'd0;
            busy      <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (frame_end) begin
            if (pending_valid) begin
              last_sent     <= pending_val;
              pending_valid <= 1'b0;
              char_idx      <= 4'd0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            if (tx_ready) char_idx <= char_idx + 4'd1;
            if (change) begin
              if (pending_valid) drop_count <= sat_inc8(drop_count);
              pending_valid <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Value registers: frame payload and the coalescing pending slot.
  always_ff @(posedge clk) begin
    if (start) begin
      cur_val <= x1;
    end else if (frame_end && pending_valid) begin
      cur_val <= pending_val;
    end
    if ((state == ST_SEND) && !frame_end && change) begin
      pending_val <= x1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .data  (tx_data),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx)
  );

endmodule

// File: tb/tb_x1_uart_reporter.sv
// Bench for x1_uart_reporter: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a frame-level model.
module tb_x1_uart_reporter;

  localparam int C          = 4;          // clocks per bit (16 Hz / 4 baud)
  localparam int CHAR_CYC   = 10 * C;
  localparam int FRAME_CYC  = 10 * CHAR_CYC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] x1 = 32'd0;
  logic        tx;
  logic        busy;
  logic [7:0]  drop_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  x1_uart_reporter #(
    .CLK_FREQ_HZ(16),
    .BAUD       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x1         (x1),
    .tx         (tx),
    .busy       (busy),
    .drop_count (drop_count)
  );

  // ---------------- frame-level reference model ----------------
  int          cyc = 0;
  bit          m_valid = 0;
  bit          m_busy = 0;
  int          m_fs = 0;
  logic [31:0] m_fv = '0;
  logic [31:0] m_last = '0;
  logic [31:0] m_pval = '0;
  bit          m_pv = 0;
  int          m_drops = 0;

  function automatic logic [7:0] frame_char(input int ch, input logic [31:0] v);
    logic [3:0] n;
    if (ch == 8) return 8'h0D;
    if (ch == 9) return 8'h0A;
    n = 4'(v >> (28 - 4 * ch));
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_valid = 1;
      m_busy  = 0;
      m_last  = '0;
      m_pv    = 0;
      m_drops = 0;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (x1 != m_last) begin
          m_busy = 1; m_fs = cyc; m_fv = x1; m_last = x1;
        end
      end else if (cyc - m_fs == FRAME_CYC) begin
        if (m_pv) begin
          m_fs = cyc; m_fv = m_pval; m_last = m_pval; m_pv = 0;
        end else begin
          m_busy = 0;
        end
      end else if (x1 != m_last && !(m_pv && x1 == m_pval)) begin
        if (m_pv) m_drops = (m_drops == 255) ? 255 : m_drops + 1;
        m_pval = x1;
        m_pv   = 1;
      end
    end
  end

  // Per-cycle comparison of tx, busy and drop_count against the model.
  logic       etx;
  logic [7:0] ec;
  int         off, bpos;
  always @(negedge clk) begin
    if (m_valid) begin
      if (!m_busy) etx = 1'b1;
      else begin
        off  = cyc - m_fs;
        bpos = (off % CHAR_CYC) / C;
        ec   = frame_char(off / CHAR_CYC, m_fv);
        etx  = (bpos == 0) ? 1'b0 : (bpos == 9) ? 1'b1 : ec[bpos-1];
      end
      vectors++;
      if (tx !== etx || busy !== m_busy || drop_count !== 8'(m_drops)) begin
        miscompares++;
        $display("FAIL model cycle %0d: tx=%b busy=%b drops=%0d, expected tx=%b busy=%b drops=%0d",
                 cyc, tx, busy, drop_count, etx, m_busy, m_drops);
      end
    end
  end

  // ---------------- bench UART receiver ----------------
  bit         dact = 0;
  int         dt = 0;
  int         db = 0;
  logic [7:0] dbyte = '0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (reset) dact = 0;
    else if (!dact) begin
      if (tx == 1'b0) begin dact = 1; dt = 0; end
    end else begin
      dt++;
      if (dt % C == C / 2) begin
        db = dt / C;
        if (db >= 1 && db <= 8) dbyte[db-1] = tx;
        else if (db == 9) begin rx_q.push_back(dbyte); dact = 0; end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input string name, input logic [79:0] exp);
    logic [79:0] got;
    if (rx_q.size() < 10) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: only %0d bytes received, expected 10", name, rx_q.size());
      rx_q.delete();
    end else begin
      got = '0;
      for (int i = 0; i < 10; i++) got = {got[71:0], rx_q.pop_front()};
      check(name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    rx_q.delete();
  endtask

  // ---------------- stimulus ----------------
  int          lows;
  logic [31:0] hist[4];

  initial begin
    reset = 1'b1; x1 = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // x1 held at 0: line stays idle.
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("idle_quiet", 80'(lows), 80'd0);
    check("idle_drops", 80'(drop_count), 80'd0);

    // Single report with latency and frame-length checks.
    do_reset();
    repeat (10) @(negedge clk);
    x1 = 32'h12AB_CDEF;
    @(posedge clk); #1;
    check("start_tx_low", 80'(tx), 80'd0);
    check("start_busy", 80'(busy), 80'd1);
    repeat (FRAME_CYC - 1) @(posedge clk); #1;
    check("busy_last_cycle", 80'(busy), 80'd1);
    @(posedge clk); #1;
    check("busy_drops_after", 80'(busy), 80'd0);
    expect_frame("frame_12ABCDEF", {"12ABCDEF", 8'h0D, 8'h0A});

    // Coalescing: 1 then 2,3,4 mid-frame.
    do_reset();
    x1 = 32'h1;
    @(posedge clk); @(negedge clk);
    lows = 0;
    for (int i = 1; i < 2 * FRAME_CYC; i++) begin
      if (i == 50)  x1 = 32'h2;
      if (i == 100) x1 = 32'h3;
      if (i == 150) x1 = 32'h4;
      if (busy !== 1'b1) lows++;
      @(negedge clk);
    end
    check("chain_no_gap", 80'(lows), 80'd0);
    repeat (20) @(negedge clk);
    check("chain_drops", 80'(drop_count), 80'd2);
    check("chain_idle", 80'(busy), 80'd0);
    expect_frame("frame_1", {"00000001", 8'h0D, 8'h0A});
    expect_frame("frame_4", {"00000004", 8'h0D, 8'h0A});

    // Revert to last_sent keeps the pending value.
    do_reset();
    x1 = 32'h5;
    repeat (50) @(negedge clk); x1 = 32'h6;
    repeat (50) @(negedge clk); x1 = 32'h5;
    repeat (2 * FRAME_CYC) @(negedge clk);
    check("revert_drops", 80'(drop_count), 80'd0);
    expect_frame("frame_5", {"00000005", 8'h0D, 8'h0A});
    expect_frame("frame_6", {"00000006", 8'h0D, 8'h0A});

    // Reset mid-frame, then re-report of an unchanged value.
    do_reset();
    x1 = 32'hFFFF_FFFF;
    repeat (120) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_tx", 80'(tx), 80'd1);
    check("midreset_busy", 80'(busy), 80'd0);
    @(negedge clk); reset = 1'b0;
    rx_q.delete();
    repeat (FRAME_CYC + 20) @(negedge clk);
    expect_frame("frame_FFFFFFFF", {"FFFFFFFF", 8'h0D, 8'h0A});

    // drop_count saturation.
    do_reset();
    x1 = 32'h1;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      x1 = 32'd100 + 32'(i);
    end
    @(negedge clk);
    check("sat_drops", 80'(drop_count), 80'd255);
    repeat (2 * FRAME_CYC) @(negedge clk);
    check("sat_drops_hold", 80'(drop_count), 80'd255);
    expect_frame("frame_sat_1", {"00000001", 8'h0D, 8'h0A});
    expect_frame("frame_sat_last", {"0000018F", 8'h0D, 8'h0A});

    // Randomized phase: model checks every cycle.
    do_reset();
    for (int i = 0; i < 4; i++) hist[i] = $urandom;
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0, 1:    x1 = hist[$urandom_range(0, 3)];
        2:       x1 = 32'd0;
        default: begin x1 = $urandom; hist[$urandom_range(0, 3)] = x1; end
      endcase
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1; @(negedge clk); reset = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
      else                           repeat ($urandom_range(60, 500)) @(negedge clk);
    end
    repeat (2 * FRAME_CYC + 10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
